apu_pdm_rx: RTL and testbench

//  Audio input path: drives the clock of an external PDM microphone and samples its 1-bit data.

---
 rtl/apu_pdm_rx_pkg.sv | 36 +++
 rtl/apu_cic3_decim.sv | 103 ++++++++++
 rtl/apu_pdm_rx.sv | 107 ++++++++++
 tb/tb_apu_pdm_rx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_pdm_rx_pkg.sv
// Shared APU audio definitions: sample width, CIC order, decimation limits
// and the small arithmetic helpers used by the PDM receive path.
package apu_pdm_rx_pkg;

    localparam int APU_SAMPLE_W       = 16;
    localparam int APU_CIC_ORDER      = 3;
    localparam int APU_DECIM_LOG2_MIN = 3;
    localparam int APU_DECIM_LOG2_MAX = 6;
    localparam int APU_CLKDIV_MIN     = 2;
    localparam int APU_SETTLE_COUNT   = 3;

    function automatic int acc_width(input int max_log2);
        return 1 + APU_CIC_ORDER * max_log2;
    endfunction

    function automatic logic [2:0] clamp_decim(input logic [2:0] d, input int max_log2);
        if (int'(d) < APU_DECIM_LOG2_MIN) begin
            return 3'(APU_DECIM_LOG2_MIN);
        end else if (int'(d) > max_log2) begin
            return 3'(max_log2);
        end else begin
            return d;
        end
    endfunction

    function automatic logic signed [APU_SAMPLE_W-1:0] sat_sample(input logic signed [31:0] v);
        if (v > 32'sd32767) begin
            return 16'sh7fff;
        end else if (v < -32'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[APU_SAMPLE_W-1:0];
        end
    endfunction

endpackage

// File: rtl/apu_cic3_decim.sv
// Third-order CIC decimator: integrators at the bit rate, combs at the
// decimated rate, then scaling to a saturated signed 16-bit sample.
module apu_cic3_decim
    import apu_pdm_rx_pkg::*;
#(
    parameter int MAX_DECIM_LOG2 = APU_DECIM_LOG2_MAX
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           bit_en,
    input  logic                           data_bit,
    input  logic [2:0]                     decim_log2,
    input  logic                           clr,
    output logic                           out_en,
    output logic signed [APU_SAMPLE_W-1:0] out
);

    localparam int ACC_W = acc_width(MAX_DECIM_LOG2);

    logic [ACC_W-1:0]          integ1;
    logic [ACC_W-1:0]          integ2;
    logic [ACC_W-1:0]          integ3;
    logic [ACC_W-1:0]          dly1;
    logic [ACC_W-1:0]          dly2;
    logic [ACC_W-1:0]          dly3;
    logic [ACC_W-1:0]          comb1;
    logic [ACC_W-1:0]          comb2;
    logic [ACC_W-1:0]          comb3;
    logic [MAX_DECIM_LOG2-1:0] dcnt;
    logic [MAX_DECIM_LOG2-1:0] dcnt_last;
    logic                      fire;
    logic [2:0]                dl;
    logic [4:0]                cube_log2;
    logic signed [31:0]        mapped;
    logic signed [31:0]        scaled;

    assign dl        = clamp_decim(decim_log2, MAX_DECIM_LOG2);
    assign dcnt_last = MAX_DECIM_LOG2'((32'd1 << dl) - 32'd1);
    assign cube_log2 = 5'(dl) * 5'd3;

    // The bit is accumulated as 0/1 so the comb output spans 0..R**3 without
    // sign ambiguity in ACC_W bits; it is remapped to the +1/-1 domain below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ1 <= '0;
            integ2 <= '0;
            integ3 <= '0;
            dly1   <= '0;
            dly2   <= '0;
            dly3   <= '0;
            dcnt   <= '0;
            fire   <= 1'b0;
        end else if (clr) begin
            integ1 <= '0;
            integ2 <= '0;
            integ3 <= '0;
            dly1   <= '0;
            dly2   <= '0;
            dly3   <= '0;
            dcnt   <= '0;
            fire   <= 1'b0;
        end else begin
            fire <= 1'b0;
            if (bit_en) begin
                integ1 <= integ1 + ACC_W'(data_bit);
                integ2 <= integ2 + integ1;
                integ3 <= integ3 + integ2;
                // >= keeps the counter wrapping if the ratio shrinks mid-run
                if (dcnt >= dcnt_last) begin
                    dcnt <= '0;
                    fire <= 1'b1;
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
            end
            if (fire) begin
                dly1 <= integ3;
                dly2 <= comb1;
                dly3 <= comb2;
            end
        end
    end

    always_comb begin
        comb1 = integ3 - dly1;
        comb2 = comb1 - dly2;
        comb3 = comb2 - dly3;
    end

    // +1/-1 sum = 2*ones - R**3, then bring R**3 full scale onto 2**15.
    always_comb begin
        mapped = $signed((32'(comb3) << 1) - (32'd1 << cube_log2));
        if (cube_log2 > 5'd15) begin
            scaled = mapped >>> (cube_log2 - 5'd15);
        end else begin
            scaled = mapped <<< (5'd15 - cube_log2);
        end
    end

    assign out_en = fire;
    assign out    = sat_sample(scaled);

endmodule

// File: rtl/apu_pdm_rx.sv
// PDM microphone receiver: drives pdm_clk, samples the mic's rising-edge
// channel, decimates through the CIC and presents samples on valid/ready.
module apu_pdm_rx
    import apu_pdm_rx_pkg::*;
#(
    parameter int MAX_DECIM_LOG2 = APU_DECIM_LOG2_MAX
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic [7:0]                     clkdiv,
    input  logic [2:0]                     decim_log2,
    output logic                           pdm_clk,
    input  logic                           pdm_data,
    output logic signed [APU_SAMPLE_W-1:0] sample,
    output logic                           sample_vld,
    input  logic                           sample_rdy,
    output logic                           overflow,
    input  logic                           overflow_clr
);

    // Stream handshake: sample/sample_vld hold until a cycle with
    // sample_vld && sample_rdy; that cycle is the transfer.

    logic [1:0]                     sync;
    logic [7:0]                     div_cnt;
    logic [7:0]                     div_reload;
    logic                           toggle;
    logic                           bit_en;
    logic                           cic_vld;
    logic signed [APU_SAMPLE_W-1:0] cic_out;
    logic [1:0]                     settle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], pdm_data};
        end
    end

    assign div_reload = (clkdiv < 8'(APU_CLKDIV_MIN)) ? 8'(APU_CLKDIV_MIN) : clkdiv;
    assign toggle     = (div_cnt == 8'd0);
    // Falling pdm_clk edge: the mic's rising-edge channel has settled.
    assign bit_en     = en && toggle && pdm_clk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= 8'd0;
            pdm_clk <= 1'b0;
        end else if (!en) begin
            div_cnt <= 8'd0;
            pdm_clk <= 1'b0;
        end else if (toggle) begin
            div_cnt <= div_reload;
            pdm_clk <= ~pdm_clk;
        end else begin
            div_cnt <= div_cnt - 8'd1;
        end
    end

    apu_cic3_decim #(
        .MAX_DECIM_LOG2 (MAX_DECIM_LOG2)
    ) u_cic (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_en     (bit_en),
        .data_bit   (sync[1]),
        .decim_log2 (decim_log2),
        .clr        (!en),
        .out_en     (cic_vld),
        .out        (cic_out)
    );

    // The overflow set sits after the clear so a coincident drop wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample     <= '0;
            sample_vld <= 1'b0;
            settle     <= 2'd0;
            overflow   <= 1'b0;
        end else begin
            if (overflow_clr) begin
                overflow <= 1'b0;
            end
            if (!en) begin
                sample_vld <= 1'b0;
                settle     <= 2'd0;
            end else begin
                if (sample_vld && sample_rdy) begin
                    sample_vld <= 1'b0;
                end
                if (cic_vld) begin
                    if (settle != 2'(APU_SETTLE_COUNT)) begin
                        settle <= settle + 2'd1;
                    end else if (sample_vld && !sample_rdy) begin
                        overflow <= 1'b1;
                    end else begin
                        sample     <= cic_out;
                        sample_vld <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_apu_pdm_rx.sv
// Self-checking bench for apu_pdm_rx: scoreboarded sample stream plus
// directed checks of pdm_clk timing, overflow, enable and reset behaviour.
module tb_apu_pdm_rx;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic [7:0]         clkdiv = 8'd2;
    logic [2:0]         decim_log2 = 3'd6;
    logic               pdm_clk;
    wire                pdm_data;
    logic signed [15:0] sample;
    logic               sample_vld;
    logic               sample_rdy = 1'b1;
    logic               overflow;
    logic               overflow_clr = 1'b0;

    logic level_bit = 1'b0;
    logic alt_bit   = 1'b0;
    logic alt_mode  = 1'b0;
    logic pdm_prev  = 1'b0;

    int n_cmp    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int prev_acc = 0;
    int last_acc = 0;
    int c;
    int hi;
    int lo;

    logic signed [15:0] exp_q[$];

    assign pdm_data = alt_mode ? alt_bit : level_bit;

    apu_pdm_rx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .clkdiv       (clkdiv),
        .decim_log2   (decim_log2),
        .pdm_clk      (pdm_clk),
        .pdm_data     (pdm_data),
        .sample       (sample),
        .sample_vld   (sample_vld),
        .sample_rdy   (sample_rdy),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Mic model for the alternating pattern: a new bit after each pdm_clk rise.
    always @(posedge clk) begin
        #2;
        if (alt_mode && pdm_clk && !pdm_prev) alt_bit = ~alt_bit;
        pdm_prev = pdm_clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_n(input int n, input logic signed [15:0] v);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    task automatic wait_vld(input int limit, output int cnt);
        cnt = -1;
        for (int i = 0; i < limit; i++) begin
            wait_clk(1);
            if (sample_vld) begin
                cnt = i;
                break;
            end
        end
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && exp_q.size() > 0; i++) wait_clk(1);
        check_val("drain", 32'(exp_q.size()), 0);
    endtask

    task automatic measure_pdm(output int h, output int l);
        for (int i = 0; i < 100 && pdm_clk; i++) wait_clk(1);
        for (int i = 0; i < 100 && !pdm_clk; i++) wait_clk(1);
        h = 0;
        while (pdm_clk && h < 100) begin
            h++;
            wait_clk(1);
        end
        l = 0;
        while (!pdm_clk && l < 100) begin
            l++;
            wait_clk(1);
        end
    endtask

    // Scoreboard: every transfer must match the oldest expected sample.
    always @(negedge clk) begin
        if (rst_n && sample_vld && sample_rdy) begin
            check_val("exp_avail", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check_val("sample", 32'(sample), 32'(exp_q.pop_front()));
            prev_acc = last_acc;
            last_acc = cyc;
        end
    end

    initial begin
        wait_clk(3);
        check_val("rst_pdm_clk", 32'(pdm_clk), 0);
        check_val("rst_sample", 32'(sample), 0);
        check_val("rst_vld", 32'(sample_vld), 0);
        check_val("rst_ovf", 32'(overflow), 0);
        rst_n = 1'b1;
        wait_clk(2);

        // All ones, R=64: full positive scale after three discards.
        level_bit = 1'b1;
        wait_clk(3);
        push_n(3, 16'sh7fff);
        en = 1'b1;
        wait_vld(3000, c);
        check_val("latency_ones", 32'(c), 1534);
        drain(2000);
        check_val("interval", 32'(last_acc - prev_acc), 384);
        en = 1'b0;
        wait_clk(2);

        // All zeros: full negative scale, same discard count.
        level_bit = 1'b0;
        wait_clk(3);
        push_n(3, 16'sh8000);
        en = 1'b1;
        wait_vld(3000, c);
        check_val("latency_zeros", 32'(c), 1534);
        drain(2000);
        en = 1'b0;
        wait_clk(2);

        // Alternating bits, R=8: zero mean.
        decim_log2 = 3'd3;
        alt_mode = 1'b1;
        push_n(6, 16'sd0);
        en = 1'b1;
        drain(1000);
        en = 1'b0;
        alt_mode = 1'b0;
        wait_clk(2);

        // Back-pressure: hold first, drop second, overflow handling.
        level_bit = 1'b1;
        sample_rdy = 1'b0;
        wait_clk(3);
        en = 1'b1;
        wait_vld(1000, c);
        check_val("held_first", 32'(sample), 32'(16'sh7fff));
        wait_clk(60);
        check_val("held_still", 32'(sample), 32'(16'sh7fff));
        check_val("held_vld", 32'(sample_vld), 1);
        check_val("ovf_set", 32'(overflow), 1);
        push_n(1, 16'sh7fff);
        sample_rdy = 1'b1;
        wait_clk(1);
        sample_rdy = 1'b0;
        check_val("vld_drop", 32'(sample_vld), 0);
        overflow_clr = 1'b1;
        wait_clk(1);
        overflow_clr = 1'b0;
        check_val("ovf_clr", 32'(overflow), 0);
        wait_vld(200, c);
        check_val("vld_again", 32'(sample_vld), 1);
        wait_clk(47);
        overflow_clr = 1'b1;
        wait_clk(1);
        overflow_clr = 1'b0;
        check_val("ovf_set_wins", 32'(overflow), 1);

        // Disable with a pending sample.
        en = 1'b0;
        wait_clk(1);
        check_val("dis_pdm_clk", 32'(pdm_clk), 0);
        check_val("dis_vld", 32'(sample_vld), 0);
        check_val("dis_ovf_kept", 32'(overflow), 1);
        overflow_clr = 1'b1;
        wait_clk(1);
        overflow_clr = 1'b0;
        level_bit = 1'b0;
        sample_rdy = 1'b1;
        wait_clk(3);
        push_n(3, 16'sh8000);
        en = 1'b1;
        wait_vld(500, c);
        check_val("latency_reen", 32'(c), 190);
        drain(500);

        // Asynchronous reset mid-run.
        sample_rdy = 1'b0;
        wait_clk(150);
        check_val("pre_rst_ovf", 32'(overflow), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_pdm_clk", 32'(pdm_clk), 0);
        check_val("arst_sample", 32'(sample), 0);
        check_val("arst_vld", 32'(sample_vld), 0);
        check_val("arst_ovf", 32'(overflow), 0);
        en = 1'b0;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(2);

        // pdm_clk period and duty.
        decim_log2 = 3'd6;
        clkdiv = 8'd4;
        en = 1'b1;
        measure_pdm(hi, lo);
        check_val("div4_hi", 32'(hi), 5);
        check_val("div4_lo", 32'(lo), 5);
        en = 1'b0;
        wait_clk(2);
        clkdiv = 8'd0;
        en = 1'b1;
        measure_pdm(hi, lo);
        check_val("div0_period", 32'(hi + lo), 6);
        en = 1'b0;
        wait_clk(2);
        clkdiv = 8'd1;
        en = 1'b1;
        measure_pdm(hi, lo);
        check_val("div1_period", 32'(hi + lo), 6);
        check_val("div1_hi", 32'(hi), 3);
        en = 1'b0;
        wait_clk(2);

        check_val("exp_q_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
